// File: rtl/logic_reduce_pkg.sv
// Shared types and parameter-legality constants for the logic_reduce_pipe block.
package logic_reduce_pkg;

  localparam int unsigned NMin = 3;
  localparam int unsigned NMax = 64;
  localparam int unsigned KMin = 1;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

  function automatic logic nk_legal(input int unsigned n, input int unsigned k);
    return (n >= NMin) && (n <= NMax) && (k >= KMin) && (k < n);
  endfunction

endpackage

// File: rtl/logic_reduce_skid.sv
// Two-entry skid buffer with registered in_ready; slot0 always holds the oldest beat.
module logic_reduce_skid
  import logic_reduce_pkg::*;
#(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  buf_state_e       state_q, state_d;
  logic [Width-1:0] slot0_q, slot0_d;
  logic [Width-1:0] slot1_q, slot1_d;
  logic             in_ready_q;
  logic             accept;
  logic             deliver;

  assign accept      = in_valid_i & in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign deliver     = out_valid_o & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_valid_o ? slot0_q : '0;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          slot0_d = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          slot0_d = in_data_i;
        end else if (accept) begin
          slot1_d = in_data_i;
          state_d = StFull;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (deliver) begin
          slot0_d = slot1_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StEmpty;
      slot0_q    <= '0;
      slot1_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      // Registered ready derived from next state, so FULL is seen one edge early.
      in_ready_q <= (state_d != StFull);
    end
  end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Reduces x[K-1:0] by mode into f, ORs in x[N-1:K] for g, and buffers the pair.
// Optional hit counter enabled by defining LOGIC_REDUCE_PIPE_HIT_CNT_EN.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned K     = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     x_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             f_o,
  output logic             g_o
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
  ,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] hit_cnt_o
`endif
);

  if (!nk_legal(N, K) || (CNT_W < 1)) begin : g_param_err
    $error("logic_reduce_pipe: illegal parameters N=%0d K=%0d CNT_W=%0d", N, K, CNT_W);
  end

  logic [K-1:0] x_lo;
  logic         hi_any;
  logic         f_new;
  logic         g_new;
  logic [1:0]   pair_out;

  assign x_lo   = x_i[K-1:0];
  assign hi_any = |x_i[N-1:K];

  always_comb begin
    f_new = 1'b0;
    unique case (mode_e'(mode_i))
      MODE_AND:  f_new = &x_lo;
      MODE_OR:   f_new = |x_lo;
      MODE_XOR:  f_new = ^x_lo;
      MODE_NAND: f_new = ~&x_lo;
    endcase
  end

  assign g_new = f_new | hi_any;

  logic_reduce_skid #(
    .Width(2)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  ({f_new, g_new}),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (pair_out)
  );

  assign f_o = pair_out[1];
  assign g_o = pair_out[0];

`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a coincident counted delivery.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (out_valid_o && out_ready_i && g_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench: two DUTs (N=3/K=2 and N=8/K=4) share one handshake stream.
module tb_logic_reduce_pipe;

  localparam int unsigned NA = 3;
  localparam int unsigned KA = 2;
  localparam int unsigned NB = 8;
  localparam int unsigned KB = 4;
  localparam int unsigned CW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] x;
  logic [1:0] mode;
  logic       in_ready_a, in_ready_b;
  logic       out_valid_a, out_valid_b;
  logic       f_a, g_a, f_b, g_b;
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
  logic          cnt_clr;
  logic [CW-1:0] hit_a, hit_b;
  int unsigned   exp_hit_a, exp_hit_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int deliv_cnt = 0;
  int acc_cnt = 0;
  logic armed = 1'b0;
  logic [3:0] sb_q[$];  // {fa, ga, fb, gb}

  always #5 clk = ~clk;

  logic_reduce_pipe #(.N(NA), .K(KA), .CNT_W(CW)) dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_a),
    .x_i        (x[NA-1:0]),
    .mode_i     (mode),
    .out_valid_o(out_valid_a),
    .out_ready_i(out_ready),
    .f_o        (f_a),
    .g_o        (g_a)
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
    ,
    .cnt_clr_i  (cnt_clr),
    .hit_cnt_o  (hit_a)
`endif
  );

  logic_reduce_pipe #(.N(NB), .K(KB), .CNT_W(CW)) dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_b),
    .x_i        (x),
    .mode_i     (mode),
    .out_valid_o(out_valid_b),
    .out_ready_i(out_ready),
    .f_o        (f_b),
    .g_o        (g_b)
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
    ,
    .cnt_clr_i  (cnt_clr),
    .hit_cnt_o  (hit_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: reduce the K low bits per the operator, g adds any high bit of the N-bit vector.
  function automatic logic [1:0] ref_fg(input logic [7:0] xv, input int unsigned n,
                                        input int unsigned k, input logic [1:0] m);
    logic [7:0] lowmask;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       f;
    lowmask = 8'((9'd1 << k) - 9'd1);
    lo      = xv & lowmask;
    hi      = (xv & 8'((9'd1 << n) - 9'd1)) >> k;
    case (m)
      2'd0:    f = (lo == lowmask);
      2'd1:    f = (lo != 8'd0);
      2'd2:    f = ($countones(lo) % 2) == 1;
      default: f = (lo != lowmask);
    endcase
    return {f, f || (hi != 8'd0)};
  endfunction

  initial forever begin
    @(posedge clk);
    armed = !rst;
  end

  // Scoreboard/monitor: values seen at negedge are what the next rising edge acts on.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      chk("rst_out_valid", {31'd0, out_valid_b}, 0);
      chk("rst_in_ready", {31'd0, in_ready_b}, 0);
      chk("rst_fg_b", {30'd0, f_b, g_b}, 0);
      chk("rst_fg_a", {30'd0, f_a, g_a}, 0);
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
      exp_hit_a = 0;
      exp_hit_b = 0;
      chk("rst_hit", {30'd0, hit_b}, 0);
`endif
    end else begin
      logic exp_rdy, exp_vld, acc, dlv;
      exp_vld = (sb_q.size() != 0);
      exp_rdy = armed && (sb_q.size() < 2);
      acc     = in_valid && exp_rdy;
      dlv     = exp_vld && out_ready;
      chk("out_valid_b", {31'd0, out_valid_b}, {31'd0, exp_vld});
      chk("out_valid_a", {31'd0, out_valid_a}, {31'd0, exp_vld});
      chk("in_ready_b", {31'd0, in_ready_b}, {31'd0, exp_rdy});
      chk("in_ready_a", {31'd0, in_ready_a}, {31'd0, exp_rdy});
      if (exp_vld) begin
        chk("fg_a", {30'd0, f_a, g_a}, {30'd0, sb_q[0][3:2]});
        chk("fg_b", {30'd0, f_b, g_b}, {30'd0, sb_q[0][1:0]});
      end
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
      chk("hit_a", {30'd0, hit_a}, exp_hit_a);
      chk("hit_b", {30'd0, hit_b}, exp_hit_b);
      if (cnt_clr) begin
        exp_hit_a = 0;
        exp_hit_b = 0;
      end else if (dlv) begin
        if (sb_q[0][2] && exp_hit_a < 3) exp_hit_a++;
        if (sb_q[0][0] && exp_hit_b < 3) exp_hit_b++;
      end
`endif
      if (dlv) begin
        void'(sb_q.pop_front());
        deliv_cnt++;
      end
      if (acc) begin
        sb_q.push_back({ref_fg(x, NA, KA, mode), ref_fg(x, NB, KB, mode)});
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] xv, input logic [1:0] mv);
    int   tries;
    logic acc;
    tries = 0;
    in_valid = 1'b1;
    x = xv;
    mode = mv;
    do begin
      @(negedge clk);
      acc = in_ready_b;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int tries;
    tries = 0;
    while ((sb_q.size() != 0 || out_valid_b) && tries < 50) begin
      @(posedge clk);
      #1;
      tries++;
    end
    chk("drain", {31'd0, out_valid_b}, 0);
  endtask

  initial begin
    int d0, a0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    mode = '0;
`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_before_edge", {31'd0, in_ready_b}, 0);
    @(posedge clk);
    #1 chk("ready_after_rst", {31'd0, in_ready_b}, 1);

    // Directed vectors; first one also checks single-cycle latency.
    send(8'h03, 2'd0);
    chk("latency_out_valid", {31'd0, out_valid_b}, 1);
    send(8'h01, 2'd0);
    send(8'h05, 2'd0);
    for (int m = 0; m < 4; m++) send(8'h0E, 2'(m));
    send(8'h10, 2'd0);
    wait_empty();

    // Backpressure: two captured, third held off.
    out_ready = 1'b0;
    d0 = deliv_cnt;
    a0 = acc_cnt;
    send(8'($urandom), 2'($urandom));
    send(8'($urandom), 2'($urandom));
    in_valid = 1'b1;
    x = 8'($urandom);
    mode = 2'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_in_ready", {31'd0, in_ready_b}, 0);
    chk("bp_captured", acc_cnt - a0, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && acc_cnt - a0 < 3; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_empty();
    chk("bp_delivered", deliv_cnt - d0, 3);

    // Streaming: 100 beats, 101 cycles.
    d0 = deliv_cnt;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      x = 8'($urandom);
      mode = 2'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("stream_deliveries", deliv_cnt - d0, 100);
    wait_empty();

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    send(8'hFF, 2'd1);
    send(8'hFF, 2'd1);
    chk("full_in_ready", {31'd0, in_ready_b}, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid_b}, 0);
    chk("async_fg", {30'd0, f_b, g_b}, 0);
    chk("async_out_valid_a", {31'd0, out_valid_a}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, in_ready_b}, 1);
    chk("post_rst_no_stale", {31'd0, out_valid_b}, 0);
    repeat (3) @(posedge clk);
    #1;

`ifdef LOGIC_REDUCE_PIPE_HIT_CNT_EN
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hFF, 2'd1);
    wait_empty();
    chk("hit_saturated", {30'd0, hit_b}, 3);
    out_ready = 1'b0;
    send(8'hFF, 2'd1);
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("hit_clr_with_delivery", {30'd0, hit_b}, 0);
    chk("hit_clr_with_delivery_a", {30'd0, hit_a}, 0);
    wait_empty();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_reduce_pipe.md
LOGIC_REDUCE_PIPE -- requirements
Module: logic_reduce_pipe

Interface
REQ-001 Parameter N, default 3, input vector width; legal range 3..64.
REQ-002 Parameter K, default 2, number of low bits feeding the f reduction; legal range 1..N-1.
REQ-003 Parameter CNT_W, default 8, width of the hit counter.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 x  input  N  operand vector.
REQ-009 mode  input  2  f reduction operator: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 f  output  1  result: reduction of x[K-1:0] by mode.
REQ-013 g  output  1  result: f OR (OR-reduce of x[N-1:K]).
REQ-014 cnt_clr  input  1  synchronous clear of hit_cnt (present only with the macro).
REQ-015 hit_cnt  output  CNT_W  count of delivered beats with g=1 (present only with the macro).

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1 on a rising edge; mode is sampled with the same beat.
REQ-017 A beat is delivered when out_valid and out_ready are both 1 on a rising edge.
REQ-018 f and g are computed combinationally from the accepted beat and stored as a pair; g always uses the f of the same beat.
REQ-019 Latency: out_valid rises on the cycle after acceptance when the output stage is empty.
REQ-020 Storage is a 2-entry skid buffer with states EMPTY, ONE, and FULL.
REQ-021 EMPTY -> ONE on accept.
REQ-022 ONE -> FULL on accept without deliver; ONE -> EMPTY on deliver without accept; ONE -> ONE on simultaneous accept and deliver.
REQ-023 FULL -> ONE on deliver; accept cannot occur in FULL.
REQ-024 in_ready is a registered signal, 1 in EMPTY and ONE, 0 in FULL.
REQ-025 out_valid is 1 in ONE and FULL.
REQ-026 f and g always present the oldest stored beat and remain stable while out_valid=1 and out_ready=0.
REQ-027 Beats are delivered in acceptance order, with none lost or duplicated.
REQ-028 Under continuous in_valid=1 and out_ready=1, throughput is one beat per cycle.
REQ-029 in_valid=1 while in_ready=0 is ignored; the beat is not captured.

Reset
REQ-030 While Reset=1: state EMPTY, in_ready=0, out_valid=0, f=0, g=0, hit_cnt=0.
REQ-031 On the first rising edge after Reset falls, in_ready becomes 1.
REQ-032 An assertion of Reset mid-operation discards all stored beats immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro LOGIC_REDUCE_PIPE_HIT_CNT_EN controls the hit counter.
REQ-034 With the macro defined, hit_cnt increments by 1 on each delivered beat with g=1.
REQ-035 With the macro defined, hit_cnt saturates at 2^CNT_W-1.
REQ-036 With the macro defined, cnt_clr=1 zeroes hit_cnt; if cnt_clr coincides with a counted delivery, the result is 0.
REQ-037 Without the macro, the cnt_clr and hit_cnt ports and all counter logic are absent; the handshake and data behaviour are unchanged.

Structure
REQ-038 Package logic_reduce_pkg holds the mode enum typedef (MODE_AND, MODE_OR, MODE_XOR, MODE_NAND) and the buffer-state enum typedef.
REQ-039 Package logic_reduce_pkg holds the N/K legality constants.
REQ-040 The 2-entry buffer is a sub-module, logic_reduce_skid, parametrised on payload width (2 bits here).
REQ-041 An elaboration-time check rejects K<1 or K>=N.

Verification
REQ-042 N=3, K=2, mode=0, x=3'b011, out_ready=1 -> next cycle out_valid=1, f=1, g=1; x=3'b001 -> f=0, g=0; x=3'b101 -> f=0, g=1.
REQ-043 N=8, K=4, x=8'h0E, modes 0/1/2/3 -> f=0/1/1/1, g=0/1/1/1; x=8'h10, mode 0 -> f=0, g=1.
REQ-044 Backpressure: out_ready=0 and three beats offered -> two beats captured, in_ready=0, third held off; then out_ready=1 -> all three delivered in order with no duplication.
REQ-045 Streaming: 100 random beats with in_valid=1 and out_ready=1 -> 100 deliveries in 101 cycles, each matching a reference model.
REQ-046 Reset asserted in the FULL state -> out_valid=0 and f=g=0 immediately; after Reset is released, the state is EMPTY and no stale beat appears.
REQ-047 With the macro defined and CNT_W=2: five g=1 deliveries -> hit_cnt=3; cnt_clr pulsed together with a g=1 delivery -> hit_cnt=0.
